// File: rtl/aes_key_sched_if.sv
// aes_key_sched_if: command channel between a key-load master and the key scheduler.
// Latency: none, plain wires; ready/err are driven by the scheduler.
// Backpressure: init is only honoured while ready=1; abort cancels a running expansion.
// Signals: key (left-aligned), keylen, slot, init, abort (master->sched); ready, err (sched->master).
interface aes_key_sched_if #(
  parameter int SLOT_W = 1
);
  logic [255:0]      key;
  logic [1:0]        keylen;
  logic [SLOT_W-1:0] slot;
  logic              init;
  logic              abort;
  logic              ready;
  logic              err;

  modport master (
    output key, keylen, slot, init, abort,
    input  ready, err
  );

  modport slave (
    input  key, keylen, slot, init, abort,
    output ready, err
  );
endinterface

// File: rtl/aes_key_sched.sv
// aes_key_sched: multi-slot AES-128/192/256 round-key expander, one 32-bit word per cycle.
// Latency: ready low for Nw+2 cycles (46/54/62) after an accepted init; round_key read is combinational.
// Backpressure: init sampled only while ready=1 (dropped otherwise); illegal init pulses err for one cycle.
// Ports: clk, reset_n; ctl (slave side of the command interface); slot_valid per stored slot;
//        rd_slot/rd_round -> round_key read port; sboxw -> external S-box -> new_sboxw (same cycle).
module aes_key_sched #(
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_W    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  aes_key_sched_if.slave       ctl,
  output logic [NUM_SLOTS-1:0] slot_valid,
  input  logic [SLOT_W-1:0]    rd_slot,
  input  logic [3:0]           rd_round,
  output logic [127:0]         round_key,
  output logic [31:0]          sboxw,
  input  logic [31:0]          new_sboxw
);

  // Storage is indexed by the full slot field; entries at or above NUM_SLOTS are never written.
  localparam int DEPTH = 1 << SLOT_W;
  localparam logic [SLOT_W:0] NSLOTS = NUM_SLOTS[SLOT_W:0];

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q;
  logic              err_q;
  logic              commit_q;
  logic [255:0]      key_q;
  logic [1:0]        klen_q;
  logic [SLOT_W-1:0] slot_q;
  logic [5:0]        idx_q;
  logic [2:0]        phase_q;
  logic [7:0]        rcon_q;
  logic [31:0]       hist_q [0:7];

  logic [31:0]       mem      [0:DEPTH-1][0:59];
  logic [1:0]        mem_klen [0:DEPTH-1];

  logic              accept;
  logic              reject;
  logic              do_write;
  logic              in_key;
  logic              rot_step;
  logic [31:0]       t_word;
  logic [31:0]       w_old;
  logic [31:0]       w_new;

  logic              rd_ok;
  logic [5:0]        rd_base;

  function automatic logic [5:0] nk_of(input logic [1:0] kl);
    case (kl)
      2'd1:    nk_of = 6'd6;
      2'd2:    nk_of = 6'd8;
      default: nk_of = 6'd4;
    endcase
  endfunction

  function automatic logic [2:0] phase_last_of(input logic [1:0] kl);
    case (kl)
      2'd1:    phase_last_of = 3'd5;
      2'd2:    phase_last_of = 3'd7;
      default: phase_last_of = 3'd3;
    endcase
  endfunction

  function automatic logic [5:0] last_idx_of(input logic [1:0] kl);
    case (kl)
      2'd1:    last_idx_of = 6'd51;
      2'd2:    last_idx_of = 6'd59;
      default: last_idx_of = 6'd43;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      2'd1:    nr_of = 4'd12;
      2'd2:    nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM next-state and per-cycle strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    do_write = 1'b0;
    case (state_q)
      IDLE: begin
        // ready_q also gates the one-cycle commit gap after DONE.
        if (ctl.init && ready_q) begin
          if (ctl.keylen == 2'd3 || {1'b0, ctl.slot} >= NSLOTS) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = GEN;
          end
        end
      end
      GEN: begin
        if (ctl.abort) begin
          state_d = IDLE;
        end else begin
          do_write = 1'b1;
          if (idx_q == last_idx_of(klen_q)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next key word. hist_q[0] is w[i-1], so w[i-Nk] sits at hist_q[Nk-1].
  // SubWord is bytewise, so rotating the S-box output equals RotWord before SubWord.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_key   = (idx_q < nk_of(klen_q));
    rot_step = !in_key && (phase_q == 3'd0);
    t_word   = hist_q[0];
    if (rot_step) begin
      t_word = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h0};
    end else if (!in_key && klen_q == 2'd2 && phase_q == 3'd4) begin
      t_word = new_sboxw;
    end
    case (klen_q)
      2'd1:    w_old = hist_q[5];
      2'd2:    w_old = hist_q[7];
      default: w_old = hist_q[3];
    endcase
    w_new = in_key ? key_q[255:224] : (w_old ^ t_word);
  end

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      commit_q   <= 1'b0;
      slot_valid <= '0;
      key_q      <= '0;
      klen_q     <= 2'd0;
      slot_q     <= '0;
      idx_q      <= 6'd0;
      phase_q    <= 3'd0;
      rcon_q     <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        hist_q[k] <= 32'h0;
      end
    end else begin
      state_q  <= state_d;
      err_q    <= reject;
      // ready/slot_valid are published one cycle after DONE.
      commit_q <= (state_q == DONE);

      if (accept) begin
        key_q   <= ctl.key;
        klen_q  <= ctl.keylen;
        slot_q  <= ctl.slot;
        idx_q   <= 6'd0;
        phase_q <= 3'd0;
        rcon_q  <= 8'h01;
        ready_q <= 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (ctl.slot == s[SLOT_W-1:0]) begin
            slot_valid[s] <= 1'b0;
          end
        end
      end

      if (do_write) begin
        // Key words are consumed from the top of key_q.
        key_q <= {key_q[223:0], 32'h0};
        for (int k = 7; k > 0; k--) begin
          hist_q[k] <= hist_q[k-1];
        end
        hist_q[0] <= w_new;
        idx_q     <= idx_q + 6'd1;
        phase_q   <= (phase_q == phase_last_of(klen_q)) ? 3'd0 : phase_q + 3'd1;
        if (rot_step) begin
          rcon_q <= xtime(rcon_q);
        end
      end

      if (state_q == GEN && ctl.abort) begin
        ready_q <= 1'b1;
      end

      if (commit_q) begin
        ready_q <= 1'b1;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (slot_q == s[SLOT_W-1:0]) begin
            slot_valid[s] <= 1'b1;
          end
        end
      end
    end
  end

  // Schedule storage; contents are only visible through slot_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[slot_q][idx_q] <= w_new;
    end
    if (accept) begin
      mem_klen[ctl.slot] <= ctl.keylen;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read port
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ok = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (rd_slot == s[SLOT_W-1:0] && slot_valid[s]) begin
        rd_ok = 1'b1;
      end
    end
    rd_base   = {rd_round, 2'b00};
    round_key = 128'h0;
    if (rd_ok && rd_round <= nr_of(mem_klen[rd_slot])) begin
      round_key = {mem[rd_slot][rd_base],
                   mem[rd_slot][rd_base + 6'd1],
                   mem[rd_slot][rd_base + 6'd2],
                   mem[rd_slot][rd_base + 6'd3]};
    end
  end

  assign sboxw     = hist_q[0];
  assign ctl.ready = ready_q;
  assign ctl.err   = err_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: directed bench for aes_key_sched with an in-bench FIPS-197 reference model.
// Latency: model tracks ready/err/slot_valid cycle by cycle from accepted commands.
// Backpressure: commands are driven only when the model says they will be sampled.
module tb_aes_key_sched;

  localparam int NS = 3;
  localparam int SW = 2;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NS-1:0] slot_valid;
  logic [SW-1:0] rd_slot;
  logic [3:0]    rd_round;
  logic [127:0]  round_key;
  logic [31:0]   sboxw;
  logic [31:0]   new_sboxw;

  aes_key_sched_if #(.SLOT_W(SW)) ctl ();

  aes_key_sched #(.NUM_SLOTS(NS), .SLOT_W(SW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ctl        (ctl),
    .slot_valid (slot_valid),
    .rd_slot    (rd_slot),
    .rd_round   (rd_round),
    .round_key  (round_key),
    .sboxw      (sboxw),
    .new_sboxw  (new_sboxw)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- GF(2^8) arithmetic and S-box ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int c = 1; c < 256; c++) begin
      if (a != 8'h00 && gf_mul(a, c[7:0]) == 8'h01) inv = c[7:0];
    end
    s = inv ^ 8'h63;
    for (int r = 1; r <= 4; r++) begin
      s = s ^ ((inv << r) | (inv >> (8 - r)));
    end
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign new_sboxw = sub_word(sboxw);

  // ---------------- reference key expansion ----------------
  // sched[0..2] mirror committed slots, sched[3] holds the job in flight.
  logic [31:0] sched [0:3][0:59];

  task automatic expand_into(input logic [255:0] k, input logic [1:0] kl, input int dst);
    int nk;
    int nw;
    logic [7:0]  rc;
    logic [31:0] t;
    nk = 4 + 2 * int'(kl);
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) sched[dst][i] = k[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = sched[dst][i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = sub_word(t);
      end
      sched[dst][i] = sched[dst][i-nk] ^ t;
    end
  endtask

  // ---------------- cycle model ----------------
  logic          m_ready = 1'b1;
  logic          m_err   = 1'b0;
  logic [NS-1:0] m_valid = '0;
  logic          m_busy  = 1'b0;
  int            m_k     = 0;
  int            m_nw    = 44;
  int            m_slot  = 0;
  int            m_nr [0:NS-1];

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_ready = 1'b1; m_err = 1'b0; m_valid = '0; m_busy = 1'b0; m_k = 0;
      end else begin
        m_err = 1'b0;
        if (m_busy) begin
          m_k++;
          if (m_k <= m_nw && ctl.abort) begin
            m_busy = 1'b0; m_ready = 1'b1;
          end else if (m_k == m_nw + 2) begin
            m_busy = 1'b0; m_ready = 1'b1; m_valid[m_slot] = 1'b1;
            for (int i = 0; i < 60; i++) sched[m_slot][i] = sched[3][i];
            m_nr[m_slot] = m_nw / 4 - 1;
          end
        end else if (m_ready && ctl.init) begin
          if (ctl.keylen == 2'd3 || int'(ctl.slot) >= NS) begin
            m_err = 1'b1;
          end else begin
            m_busy = 1'b1; m_k = 0; m_ready = 1'b0;
            m_slot = int'(ctl.slot);
            m_valid[m_slot] = 1'b0;
            m_nw = 4 * (4 + 2 * int'(ctl.keylen) + 7);
            expand_into(ctl.key, ctl.keylen, 3);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [127:0] exp_rk;
    int           r;
    int           s;
    int           j;
    forever begin
      @(negedge clk);
      chk("ready", ctl.ready, m_ready);
      chk("err", ctl.err, m_err);
      chk("slot_valid", slot_valid, m_valid);
      exp_rk = 128'h0;
      s = int'(rd_slot);
      r = int'(rd_round);
      if (s < NS && m_valid[s] && r <= m_nr[s])
        exp_rk = {sched[s][4*r], sched[s][4*r+1], sched[s][4*r+2], sched[s][4*r+3]};
      chk("round_key", round_key, exp_rk);
      if (!reset_n) begin
        chk("sboxw_reset", sboxw, 128'h0);
      end else if (m_busy && m_k >= 1) begin
        j = (m_k < m_nw) ? m_k : m_nw;
        chk("sboxw", sboxw, sched[3][j-1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [255:0] k, input logic [1:0] kl, input logic [SW-1:0] s);
    @(posedge clk); #1;
    ctl.key = k; ctl.keylen = kl; ctl.slot = s; ctl.init = 1'b1;
    @(posedge clk); #1;
    ctl.init = 1'b0;
  endtask

  task automatic wait_ready(input bit wiggle, output int lat);
    int n = 0;
    while (ctl.ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (wiggle) begin
        rd_slot  = (n % 2 == 1) ? 2'd1 : 2'd0;
        rd_round = 4'(n % 16);
      end
    end
    if (n >= 300) $display("FAIL wait_ready: timeout after %0d cycles", n);
    lat = n;
  endtask

  task automatic read_chk(input string name, input logic [SW-1:0] s, input logic [3:0] r,
                          input logic [127:0] exp);
    rd_slot = s; rd_round = r; #1;
    chk(name, round_key, exp);
  endtask

  initial begin
    int lat;
    ctl.key = '0; ctl.keylen = 2'd0; ctl.slot = '0; ctl.init = 1'b0; ctl.abort = 1'b0;
    rd_slot = '0; rd_round = 4'd0;

    // Pin the reference model to published values.
    chk("model_sbox00", sbox(8'h00), 128'h63);
    chk("model_sbox53", sbox(8'h53), 128'hed);
    expand_into(K128, 2'd0, 3);
    chk("model_128_r10", {sched[3][40], sched[3][41], sched[3][42], sched[3][43]}, R10_128);
    expand_into(K192, 2'd1, 3);
    chk("model_192_r12", {sched[3][48], sched[3][49], sched[3][50], sched[3][51]}, R12_192);
    expand_into(K256, 2'd2, 3);
    chk("model_256_r14", {sched[3][56], sched[3][57], sched[3][58], sched[3][59]}, R14_256);

    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    chk("rst_ready", ctl.ready, 128'h1);
    chk("rst_err", ctl.err, 128'h0);
    chk("rst_valid", slot_valid, 128'h0);
    chk("rst_sboxw", sboxw, 128'h0);
    chk("rst_rk", round_key, 128'h0);

    issue(K128, 2'd0, 2'd0);
    wait_ready(1'b0, lat);
    chk("lat_128", lat, 128'd46);
    read_chk("k128_r0", 2'd0, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_chk("k128_r10", 2'd0, 4'd10, R10_128);
    read_chk("k128_r11", 2'd0, 4'd11, 128'h0);

    issue(K192, 2'd1, 2'd1);
    wait_ready(1'b0, lat);
    chk("lat_192", lat, 128'd54);
    read_chk("k192_r12", 2'd1, 4'd12, R12_192);

    issue(K256, 2'd2, 2'd2);
    wait_ready(1'b0, lat);
    chk("lat_256", lat, 128'd62);
    read_chk("k256_r14", 2'd2, 4'd14, R14_256);
    read_chk("k256_r15", 2'd2, 4'd15, 128'h0);
    read_chk("slot3_rd", 2'd3, 4'd0, 128'h0);

    // Re-expand slot 1 as AES-256 while reading slots 0 and 1 every cycle.
    issue(K256, 2'd2, 2'd1);
    read_chk("s1_cleared", 2'd1, 4'd0, 128'h0);
    wait_ready(1'b1, lat);
    chk("lat_256_s1", lat, 128'd62);
    read_chk("s1_r14", 2'd1, 4'd14, R14_256);
    read_chk("s0_kept", 2'd0, 4'd10, R10_128);

    // Rejected commands.
    issue(K128, 2'd3, 2'd0);
    chk("err_keylen3", ctl.err, 128'h1);
    chk("err_kl3_ready", ctl.ready, 128'h1);
    chk("err_kl3_valid", slot_valid, 128'h7);
    @(posedge clk); #1;
    chk("err_one_cycle", ctl.err, 128'h0);
    issue(K128, 2'd0, 2'd3);
    chk("err_slot3", ctl.err, 128'h1);
    chk("err_s3_valid", slot_valid, 128'h7);

    // Abort at GEN cycle 20, then re-init immediately.
    issue(K192, 2'd0, 2'd0);
    repeat (19) @(posedge clk);
    #1 ctl.abort = 1'b1;
    @(posedge clk); #1;
    ctl.abort = 1'b0;
    chk("abort_ready", ctl.ready, 128'h1);
    chk("abort_valid0", slot_valid[0], 128'h0);
    ctl.key = K128; ctl.keylen = 2'd0; ctl.slot = 2'd0; ctl.init = 1'b1;
    @(posedge clk); #1;
    ctl.init = 1'b0;
    chk("reinit_busy", ctl.ready, 128'h0);
    wait_ready(1'b0, lat);
    chk("lat_reinit", lat, 128'd46);
    read_chk("reinit_r10", 2'd0, 4'd10, R10_128);

    // Reset in the middle of an expansion.
    issue(K256, 2'd2, 2'd1);
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", ctl.ready, 128'h1);
    chk("mid_rst_err", ctl.err, 128'h0);
    chk("mid_rst_valid", slot_valid, 128'h0);
    chk("mid_rst_sboxw", sboxw, 128'h0);
    chk("mid_rst_rk", round_key, 128'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Parametrised, multi-context AES round-key generator supporting 128-, 192- and 256-bit keys. It expands one 32-bit key word per cycle through a shared external S-box port. Expanded schedules are stored in `NUM_SLOTS` independent key slots, and a combinational port reads any round key back. It sits beside the AES cipher cores and lets encipher/decipher datapaths switch between pre-expanded keys without re-expansion.

## Interface
- `NUM_SLOTS`, 2: number of stored key contexts; must be ≥ 1.
- `SLOT_W`, 1: slot index width; must satisfy 2^SLOT_W ≥ NUM_SLOTS.
- `clk` in 1: the block's only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `key` in 256: key, left-aligned. 128-bit keys use [255:128], 192-bit keys use [255:64], 256-bit keys use all bits.
- `keylen` in 2: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal.
- `slot` in SLOT_W: target slot for `init`.
- `init` in 1: start expansion. Sampled only while `ready` = 1.
- `abort` in 1: cancel the expansion in progress.
- `ready` out 1: idle and able to accept `init`.
- `err` out 1: one-cycle pulse when an `init` is rejected.
- `slot_valid` out NUM_SLOTS: per slot, 1 = complete schedule stored.
- `rd_slot` in SLOT_W: read slot select.
- `rd_round` in 4: read round index.
- `round_key` out 128: combinational round key, {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- `sboxw` out 32: word sent to the external S-box.
- `new_sboxw` in 32: combinational S-box result for `sboxw`, returned in the same cycle.

## Operation
- Nk = 4/6/8 and Nr = 10/12/14 for keylen 0/1/2. Number of words Nw = 4·(Nr+1), i.e. 44/52/60.
- Storage: NUM_SLOTS × 60 words. Each slot also stores its own keylen.
- FSM states: IDLE, GEN, DONE.
- IDLE, `init` = 1:
  - If keylen = 3 or slot ≥ NUM_SLOTS: pulse `err`, stay in IDLE, change nothing else.
  - Otherwise: latch key, keylen and slot; clear `slot_valid[slot]`; set word counter i = 0; load rcon = 0x01; go to GEN.
- GEN: compute and write one word w[i] into the slot per cycle, then increment i.
  - For i < Nk: w[i] = key word i, where word 0 = key[255:224].
  - For i ≥ Nk: t = w[i−1].
    - If i mod Nk = 0: t = RotWord(SubWord(t)) ^ {rcon, 24'h0}, then rcon = xtime(rcon). xtime means shift left by 1, then XOR 0x1b if bit 7 was set.
    - Else if Nk = 8 and i mod 8 = 4: t = SubWord(t).
    - w[i] = w[i−Nk] ^ t.
  - i mod Nk is tracked with a wrapping phase counter; no divider.
  - When i = Nw−1 is written, go to DONE.
- `sboxw` is always driven with w[i−1], the newest word in an 8-word history window.
- DONE: set `slot_valid[slot]`, set `ready`, go to IDLE.
- `abort` in GEN: go to IDLE next cycle with `ready` = 1. `slot_valid[slot]` stays 0. `abort` in IDLE/DONE: ignored.
- `init` while `ready` = 0: ignored, no `err`.
- Read port:
  - `round_key` = 0 if `slot_valid[rd_slot]` = 0, or rd_slot ≥ NUM_SLOTS, or rd_round > Nr of that slot's stored keylen.
  - Otherwise it returns the stored round key.
- Expansion into slot A leaves every other slot readable and unchanged.

## Timing
- Reset values:
  - `ready` = 1, `err` = 0, `slot_valid` = 0, `round_key` = 0.
  - `sboxw` = 0 (history window cleared); FSM = IDLE; rcon = 0.
- `init` sampled at edge E: GEN occupies the Nw cycles after E, DONE the next cycle.
  - `ready` falls after E and rises Nw+2 edges after E: 46/54/62 for 128/192/256.
  - `slot_valid[slot]` rises on the same edge as `ready`.
- `err` is high exactly one cycle, the cycle after the rejected `init` edge.
- `abort` sampled at edge A: `ready` = 1 after A. The next `init` is accepted at edge A+1.
- Reset asserted mid-GEN: immediate return to reset values. All slots invalid.
- The read port has zero latency and no clock dependency.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, slot 0 → `ready` low for 46 cycles. round 0 = key; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, slot 1 → 54-cycle latency. round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → 62-cycle latency. round 14 = fe4890d1e6188d0b046df344706c631e. rd_round 15 → 0.
- Slot 0 holds the AES-128 schedule; expand AES-256 into slot 1 → slot 0 round keys unchanged throughout. Slot 1 reads 0 until `slot_valid[1]` rises.
- `init` with keylen = 3, then with slot = NUM_SLOTS → `err` pulse each time; `ready` stays 1; `slot_valid` unchanged.
- `abort` at GEN cycle 20 → `ready` = 1 next cycle and `slot_valid[slot]` = 0. Immediate re-`init` completes with correct keys. Reset pulse mid-GEN → all outputs at reset values.
